q57_priority_grant_decoder: RTL and testbench

- Consumer side of the 4-bit priority encoder interface: accepts encoded request {code[1:0], v} and turns it into a registered one-hot grant.
- Holds each grant until the granted requester acknowledges it, or until a hold timeout expires.
- Sits between the priority encoder and the four requesters; only one grant is outstanding at a time.
- Counts issued grants for debug and observation.

---
 rtl/q57_grant_pkg.sv | 18 +
 rtl/q57_decoder_2to4.sv | 12 +
 rtl/q57_priority_grant_decoder.sv | 140 ++++++++++++++
 tb/tb_q57_priority_grant_decoder.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/q57_grant_pkg.sv
// Shared types and helpers for the q57 priority grant decoder.
package q57_grant_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      RELEASE = 2'd2
   } state_t;

   localparam int N_REQ  = 4;
   localparam int CODE_W = 2;

   // One-hot expansion of a 2-bit requester index.
   function automatic logic [N_REQ-1:0] onehot4(input logic [CODE_W-1:0] code);
      onehot4 = 4'b0001 << code;
   endfunction

endpackage

// File: rtl/q57_decoder_2to4.sv
// Combinational 2-to-4 decoder with enable; en=0 yields an all-zero output.
module q57_decoder_2to4
   import q57_grant_pkg::*;
(
   input  logic              en,
   input  logic [CODE_W-1:0] sel,
   output logic [N_REQ-1:0]  dec
);

   assign dec = en ? onehot4(sel) : '0;

endmodule

// File: rtl/q57_priority_grant_decoder.sv
// Consumer of the 4-bit priority encoder interface: turns {code, v} into a
// registered one-hot grant, holds it until the owner acks or a hold timeout
// fires, and counts issued grants (saturating).
// Optional macro Q57_GRANT_LOG_EN adds last_code/last_valid completion log.
module q57_priority_grant_decoder
   import q57_grant_pkg::*;
#(
   parameter int HOLD_MAX = 15,
   parameter int CNT_W    = 8
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [CODE_W-1:0] code,
   input  logic              v,
   input  logic [N_REQ-1:0]  ack,
   output logic [N_REQ-1:0]  gnt,
   output logic              busy,
   output logic              timeout,
   output logic [CNT_W-1:0]  grant_cnt
`ifdef Q57_GRANT_LOG_EN
   ,
   output logic [CODE_W-1:0] last_code,
   output logic              last_valid
`endif
);

   // Timer value at which an un-acked grant has been visible HOLD_MAX cycles.
   localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

   state_t              state;
   state_t              state_next;
   logic [CODE_W-1:0]   code_q;
   logic [CODE_W-1:0]   code_next;
   logic [7:0]          timer;
   logic [7:0]          timer_next;
   logic [N_REQ-1:0]    gnt_next;
   logic                timeout_next;
   logic                cnt_inc;
   logic [N_REQ-1:0]    dec_gnt;
   logic                ack_hit;
   logic                expired;

   // Only the acknowledge of the current owner is honoured.
   assign ack_hit = ack[code_q];
   assign expired = (timer == HOLD_LAST);
   assign busy    = (state != IDLE);

   q57_decoder_2to4 u_dec (
      .en  (state == IDLE && v),
      .sel (code),
      .dec (dec_gnt)
   );

   // Next-state, grant, timer and timeout decisions.
   always_comb begin
      state_next   = state;
      code_next    = code_q;
      timer_next   = timer;
      gnt_next     = gnt;
      timeout_next = 1'b0;
      cnt_inc      = 1'b0;
      unique case (state)
         IDLE: begin
            gnt_next = dec_gnt;
            if (v) begin
               code_next  = code;
               timer_next = '0;
               cnt_inc    = 1'b1;
               state_next = GRANT;
            end
         end
         GRANT: begin
            // Ack takes precedence over a coincident expiry.
            if (ack_hit) begin
               gnt_next   = '0;
               state_next = RELEASE;
            end else if (expired) begin
               gnt_next     = '0;
               timeout_next = 1'b1;
               state_next   = RELEASE;
            end else begin
               timer_next = timer + 8'd1;
            end
         end
         RELEASE: begin
            gnt_next = '0;
            if (!ack_hit) begin
               state_next = IDLE;
            end
         end
         default: begin
            gnt_next   = '0;
            state_next = IDLE;
         end
      endcase
   end

   // State, owner, timer and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         code_q    <= '0;
         timer     <= '0;
         gnt       <= '0;
         timeout   <= 1'b0;
         grant_cnt <= '0;
      end else begin
         state   <= state_next;
         code_q  <= code_next;
         timer   <= timer_next;
         gnt     <= gnt_next;
         timeout <= timeout_next;
         if (cnt_inc && (grant_cnt != {CNT_W{1'b1}})) begin
            grant_cnt <= grant_cnt + 1'b1;
         end
      end
   end

`ifdef Q57_GRANT_LOG_EN
   // Record owner and outcome of every completed grant (ack=1, timeout=0).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_code  <= '0;
         last_valid <= 1'b0;
      end else if (state == GRANT) begin
         if (ack_hit) begin
            last_code  <= code_q;
            last_valid <= 1'b1;
         end else if (expired) begin
            last_code  <= code_q;
            last_valid <= 1'b0;
         end
      end
   end
`else
   // Completion log not built.
`endif

endmodule

// File: tb/tb_q57_priority_grant_decoder.sv
// Self-checking bench for q57_priority_grant_decoder (HOLD_MAX=4, CNT_W=2).
module tb_q57_priority_grant_decoder;

   localparam int HOLD = 4;
   localparam int CW   = 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] code;
   logic       v;
   logic [3:0] ack;
   logic [3:0] gnt;
   logic       busy;
   logic       timeout;
   logic [CW-1:0] grant_cnt;
`ifdef Q57_GRANT_LOG_EN
   logic [1:0] last_code;
   logic       last_valid;
`endif

   int passed = 0;
   int total  = 0;

   // Reference model: who owns the grant, how long it has been shown,
   // whether we are waiting for the owner to drop ack, and the grant count.
   int owner;
   bit granted;
   bit draining;
   int held;
   int m_cnt;
   bit m_to;
   int m_lcode;
   bit m_lvalid;

   always #5 clk = ~clk;

   q57_priority_grant_decoder #(.HOLD_MAX(HOLD), .CNT_W(CW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .code      (code),
      .v         (v),
      .ack       (ack),
      .gnt       (gnt),
      .busy      (busy),
      .timeout   (timeout),
      .grant_cnt (grant_cnt)
`ifdef Q57_GRANT_LOG_EN
      ,
      .last_code (last_code),
      .last_valid(last_valid)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      owner = 0; granted = 0; draining = 0; held = 0;
      m_cnt = 0; m_to = 0; m_lcode = 0; m_lvalid = 0;
   endtask

   // Advance the model by one clock edge using the inputs present at that edge.
   task automatic model_edge();
      m_to = 0;
      if (granted) begin
         held++;
         if (ack[owner]) begin
            granted = 0; draining = 1; m_lcode = owner; m_lvalid = 1;
         end else if (held == HOLD) begin
            granted = 0; draining = 1; m_to = 1; m_lcode = owner; m_lvalid = 0;
         end
      end else if (draining) begin
         if (!ack[owner]) draining = 0;
      end else if (v) begin
         owner = int'(code); granted = 1; held = 0;
         if (m_cnt < (1 << CW) - 1) m_cnt++;
      end
   endtask

   task automatic compare_all();
      chk("gnt",       32'(gnt),       granted ? (32'd1 << owner) : 32'd0);
      chk("busy",      32'(busy),      32'(granted | draining));
      chk("timeout",   32'(timeout),   32'(m_to));
      chk("grant_cnt", 32'(grant_cnt), 32'(m_cnt));
      chk("onehot",    32'($countones(gnt) <= 1), 32'd1);
`ifdef Q57_GRANT_LOG_EN
      chk("last_code",  32'(last_code),  32'(m_lcode));
      chk("last_valid", 32'(last_valid), 32'(m_lvalid));
`endif
   endtask

   task automatic step(input logic nv, input logic [1:0] ncode, input logic [3:0] nack);
      v = nv; code = ncode; ack = nack;
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   int exp_cnt_tab [5] = '{1, 2, 3, 3, 3};

   initial begin
      logic [1:0] c;
      logic [3:0] a;
      rst_n = 1'b0; v = 1'b0; code = 2'd0; ack = 4'd0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_cnt", 32'(grant_cnt), 32'd0);
      chk("rst_timeout", 32'(timeout), 32'd0);
      @(negedge clk); rst_n = 1'b1;

      // Basic grant, ack, drain.
      step(1'b1, 2'd2, 4'b0000);
      chk("basic_gnt", 32'(gnt), 32'h4);
      step(1'b0, 2'd0, 4'b0100);
      chk("basic_drop", 32'(gnt), 32'h0);
      step(1'b0, 2'd0, 4'b0000);
      chk("basic_idle", 32'(busy), 32'd0);

      // Foreign acks and input changes are ignored while granted.
      step(1'b1, 2'd1, 4'b0000);
      step(1'b1, 2'd3, 4'b1101);
      step(1'b1, 2'd3, 4'b1101);
      chk("wrong_ack_hold", 32'(gnt), 32'h2);
      step(1'b0, 2'd0, 4'b0010);
      chk("right_ack_drop", 32'(gnt), 32'h0);
      step(1'b0, 2'd0, 4'b0000);

      // Timeout: grant held exactly HOLD cycles then one timeout pulse.
      step(1'b1, 2'd3, 4'b0000);
      repeat (HOLD - 1) step(1'b0, 2'd0, 4'b0000);
      chk("to_still_held", 32'(gnt), 32'h8);
      step(1'b0, 2'd0, 4'b0000);
      chk("to_pulse", 32'(timeout), 32'd1);
      chk("to_gnt_off", 32'(gnt), 32'h0);
      step(1'b0, 2'd0, 4'b0000);
      chk("to_pulse_end", 32'(timeout), 32'd0);

      // Ack on the expiry cycle wins over the timeout.
      step(1'b1, 2'd0, 4'b0000);
      repeat (HOLD - 1) step(1'b0, 2'd0, 4'b0000);
      step(1'b0, 2'd0, 4'b0001);
      chk("ackexp_no_to", 32'(timeout), 32'd0);
      step(1'b0, 2'd0, 4'b0000);

      // Asynchronous reset in the middle of a grant.
      step(1'b1, 2'd2, 4'b0000);
      chk("pre_rst_gnt", 32'(gnt), 32'h4);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      chk("async_rst_gnt", 32'(gnt), 32'd0);
      chk("async_rst_busy", 32'(busy), 32'd0);
      chk("async_rst_cnt", 32'(grant_cnt), 32'd0);
      chk("async_rst_to", 32'(timeout), 32'd0);
      @(negedge clk); rst_n = 1'b1;

      // Back-to-back grants with v held high; counter saturates at 3.
      for (int i = 0; i < 5; i++) begin
         c = 2'($urandom_range(0, 3));
         step(1'b1, c, 4'b0000);
         chk("b2b_cnt", 32'(grant_cnt), 32'(exp_cnt_tab[i]));
         step(1'b1, c, 4'b0001 << c);
         step(1'b1, 2'($urandom_range(0, 3)), 4'b0000);
         chk("b2b_gap", 32'(gnt), 32'd0);
      end

      // Randomized traffic against the model.
      for (int i = 0; i < 300; i++) begin
         case ($urandom_range(0, 3))
            0: a = 4'b0000;
            1: a = 4'b0001 << owner;
            2: a = 4'($urandom);
            default: a = (4'b0001 << owner) | 4'($urandom);
         endcase
         step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
